// File: rtl/demod_16qam_if.sv
// Sample-in / symbol-out bundle of the 16QAM demodulator.
// The demodulator takes the slave view; the source/sink side takes the master view.
interface demod_16qam_if #(
    parameter int BIT_IN = 14
);
    logic signed [BIT_IN-1:0] if_in;
    logic                     sync;
    logic                     sym_valid;
    logic                     i1;
    logic                     i0;
    logic                     q1;
    logic                     q0;
    logic [15:0]              sym_cnt;
    logic [15:0]              err_cnt;
    logic                     pn_lock;

    modport slave (
        input  if_in, sync,
        output sym_valid, i1, i0, q1, q0, sym_cnt, err_cnt, pn_lock
    );

    modport master (
        output if_in, sync,
        input  sym_valid, i1, i0, q1, q0, sym_cnt, err_cnt, pn_lock
    );
endinterface

// File: rtl/demod_16qam.sv
// 16QAM IF demodulator: de-rotate, integrate-and-dump per 8-sample symbol, slice to 2+2 bits.
// Optional PN bit-error checkers are built when DEMOD_16QAM_BER_EN is defined.
module demod_16qam #(
    parameter int          SPS      = 8,
    parameter int          BIT_IN   = 14,
    parameter int          THRESH   = 4096,
    parameter logic [12:0] GEN_POLY = 13'b1_0000_1101_0001
) (
    input  logic          clock_5000,
    input  logic          reset,
    demod_16qam_if.slave  bus
);
    localparam int PW = $clog2(SPS);
    localparam int AW = BIT_IN + 2;
    localparam logic [PW-1:0]            PH_LAST = PW'(SPS - 1);
    localparam logic signed [BIT_IN-1:0] S_MIN   = {1'b1, {(BIT_IN-1){1'b0}}};
    localparam logic signed [BIT_IN-1:0] S_MAX   = {1'b0, {(BIT_IN-1){1'b1}}};
    localparam logic signed [AW-1:0]     THR_P   = AW'(THRESH);
    localparam logic signed [AW-1:0]     THR_N   = AW'(-THRESH);

    logic [PW-1:0]            phase_q, phase_d, ph_cur;
    logic signed [BIT_IN-1:0] d_q, d_d, neg_in;
    logic [PW-1:0]            d_ph_q, d_ph_d;
    logic                     d_vld_q, d_vld_d;
    logic signed [AW-1:0]     acc_i_q, acc_i_d, acc_q_q, acc_q_d, d_ext;
    logic                     full_q, full_d;
    logic                     done_q, done_d;
    logic                     sym_valid_q, sym_valid_d;
    logic [3:0]               sym_q, sym_d;
    logic [15:0]              sym_cnt_q, sym_cnt_d;

    function automatic logic [1:0] slice(input logic signed [AW-1:0] a);
        if (a >= THR_P)       slice = 2'b00;
        else if (!a[AW-1])    slice = 2'b01;
        else if (a >= THR_N)  slice = 2'b10;
        else                  slice = 2'b11;
    endfunction

    // Phase tracking and stage 1: sync re-tags the incoming sample as phase 0.
    always_comb begin
        ph_cur  = bus.sync ? '0 : phase_q;
        phase_d = ph_cur + PW'(1);
        neg_in  = (bus.if_in == S_MIN) ? S_MAX : -bus.if_in;
        d_d     = ph_cur[1] ? bus.if_in : neg_in;
        d_ph_d  = ph_cur;
        d_vld_d = 1'b1;
    end

    // Stage 2: phases 0/1 load rather than add, so a resync never mixes in stale sums.
    always_comb begin
        d_ext   = {{2{d_q[BIT_IN-1]}}, d_q};
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
        full_d  = full_q;
        done_d  = 1'b0;
        if (d_vld_q) begin
            if (!d_ph_q[0])
                acc_i_d = (d_ph_q == '0) ? d_ext : acc_i_q + d_ext;
            else
                acc_q_d = (d_ph_q == PW'(1)) ? d_ext : acc_q_q + d_ext;
            if (d_ph_q == '0)
                full_d = 1'b1;
            if (d_ph_q == PH_LAST)
                done_d = full_q;
        end
    end

    always_comb begin
        sym_valid_d = done_q;
        sym_d       = sym_q;
        sym_cnt_d   = sym_cnt_q;
        if (done_q) begin
            sym_d     = {slice(acc_i_q), slice(acc_q_q)};
            sym_cnt_d = sym_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            phase_q     <= '0;
            d_q         <= '0;
            d_ph_q      <= '0;
            d_vld_q     <= 1'b0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_q       <= '0;
            sym_cnt_q   <= '0;
        end else begin
            phase_q     <= phase_d;
            d_q         <= d_d;
            d_ph_q      <= d_ph_d;
            d_vld_q     <= d_vld_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            full_q      <= full_d;
            done_q      <= done_d;
            sym_valid_q <= sym_valid_d;
            sym_q       <= sym_d;
            sym_cnt_q   <= sym_cnt_d;
        end
    end

    assign bus.sym_valid = sym_valid_q;
    assign bus.i1        = sym_q[3];
    assign bus.i0        = sym_q[2];
    assign bus.q1        = sym_q[1];
    assign bus.q0        = sym_q[0];
    assign bus.sym_cnt   = sym_cnt_q;

`ifdef DEMOD_16QAM_BER_EN
    logic [3:0]  miss, primed;
    logic        pn_lock_q, pn_lock_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    // One self-synchronising checker per symbol bit; index matches sym_q bit order.
    for (genvar gi = 0; gi < 4; gi++) begin : g_chk
        logic [11:0] sr_q, sr_d;
        logic [3:0]  cnt_q, cnt_d;

        always_comb begin
            sr_d  = sr_q;
            cnt_d = cnt_q;
            if (sym_valid_q) begin
                sr_d = {sr_q[10:0], sym_q[gi]};
                if (cnt_q != 4'd12)
                    cnt_d = cnt_q + 4'd1;
            end
            if (bus.sync)
                cnt_d = '0;
        end

        always_ff @(posedge clock_5000 or negedge reset) begin
            if (!reset) begin
                sr_q  <= '0;
                cnt_q <= '0;
            end else begin
                sr_q  <= sr_d;
                cnt_q <= cnt_d;
            end
        end

        assign primed[gi] = (cnt_q == 4'd12);
        assign miss[gi]   = sym_valid_q & pn_lock_q & (sym_q[gi] ^ (^(sr_q & GEN_POLY[12:1])));
    end

    always_comb begin
        pn_lock_d = bus.sync ? 1'b0 : &primed;
        err_sum   = {1'b0, err_cnt_q} + 17'($countones(miss));
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clock_5000 or negedge reset) begin
        if (!reset) begin
            pn_lock_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            pn_lock_q <= pn_lock_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
    assign bus.pn_lock = pn_lock_q;
`else
    logic unused_gen_poly;
    assign unused_gen_poly = ^GEN_POLY;
    assign bus.err_cnt     = 16'd0;
    assign bus.pn_lock     = 1'b0;
`endif
endmodule
